// File: rtl/wb_pipelined_subordinate_if_if.sv
// Wishbone B4 pipelined bus bundle shared by the interconnect (master) and a
// core front-end (slave); signal names are seen from the subordinate side.
interface wb_pipelined_subordinate_if_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SEL_W  = 4
);
   logic [ADDR_W-1:0] i_wb_addr;
   logic [DATA_W-1:0] i_wb_dat;
   logic [DATA_W-1:0] o_wb_dat;
   logic              i_wb_cyc;
   logic              i_wb_stb;
   logic              i_wb_we;
   logic [SEL_W-1:0]  i_wb_sel;
   logic              o_wb_stall;
   logic              o_wb_ack;
   logic              o_wb_err;

   modport master (
      output i_wb_addr, i_wb_dat, i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel,
      input  o_wb_dat, o_wb_stall, o_wb_ack, o_wb_err
   );

   modport slave (
      input  i_wb_addr, i_wb_dat, i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel,
      output o_wb_dat, o_wb_stall, o_wb_ack, o_wb_err
   );
endinterface

// File: rtl/wb_pipelined_subordinate_if.sv
// Wishbone B4 pipelined subordinate front-end: standard register block at
// 0x00-0x1C, byte-enabled request/ack forwarding to the IP at 0x20 and above.
module wb_pipelined_subordinate_if #(
   parameter int unsigned                    WB_ADDRESS_WIDTH          = 32,
   parameter logic [WB_ADDRESS_WIDTH-1:0]    WB_BASE_ADDRESS           = 'h4000_0000,
   parameter int unsigned                    WB_REGISTER_ADDRESS_WIDTH = 16,
   parameter int unsigned                    WB_DATA_WIDTH             = 32,
   parameter int unsigned                    WB_DATA_GRANULARITY       = 8,
   parameter int unsigned                    IRQ_WIDTH                 = 8,
   parameter int unsigned                    IP_TIMEOUT_CYCLES         = 255,
   parameter logic [WB_DATA_WIDTH-1:0]       IP_VERSION                = 'hFFFF_FFFF,
   parameter logic [WB_DATA_WIDTH-1:0]       IP_DEVICE_ID              = 'hFFFF_FFFF
) (
   input  logic                                            i_wb_clk,
   input  logic                                            i_wb_rst,
   wb_pipelined_subordinate_if_if.slave                    wb,
   output logic [WB_REGISTER_ADDRESS_WIDTH-1:0]            o_ip_address,
   output logic [WB_DATA_WIDTH-1:0]                        o_ip_wdata,
   output logic [WB_DATA_WIDTH/WB_DATA_GRANULARITY-1:0]    o_ip_sel,
   output logic                                            o_ip_read_en,
   output logic                                            o_ip_write_en,
   input  logic [WB_DATA_WIDTH-1:0]                        i_ip_rdata,
   input  logic                                            i_ip_ack,
   output logic [WB_DATA_WIDTH-1:0]                        o_ip_control,
   input  logic [WB_DATA_WIDTH-1:0]                        i_ip_status,
   input  logic [IRQ_WIDTH-1:0]                            i_ip_irq,
   output logic                                            o_irq
);

   localparam int unsigned AW    = WB_ADDRESS_WIDTH;
   localparam int unsigned RW    = WB_REGISTER_ADDRESS_WIDTH;
   localparam int unsigned DW    = WB_DATA_WIDTH;
   localparam int unsigned GW    = WB_DATA_GRANULARITY;
   localparam int unsigned SEL_W = DW / GW;
   localparam int unsigned CNT_W = $clog2(IP_TIMEOUT_CYCLES + 1);

   localparam logic [RW-1:0]    IP_WINDOW  = RW'(32);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IP_TIMEOUT_CYCLES - 1);

   localparam logic [2:0] REG_VERSION   = 3'd0;
   localparam logic [2:0] REG_DEVICE_ID = 3'd1;
   localparam logic [2:0] REG_CONTROL   = 3'd2;
   localparam logic [2:0] REG_IRQ_MASK  = 3'd3;
   localparam logic [2:0] REG_IRQ_STAT  = 3'd4;
   localparam logic [2:0] REG_STATUS    = 3'd5;
   localparam logic [2:0] REG_IRQ_SET   = 3'd6;
   localparam logic [2:0] REG_ERROR     = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Expand per-lane selects into a bit mask.
   function automatic logic [DW-1:0] lane_mask(input logic [SEL_W-1:0] sel);
      logic [DW-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < SEL_W; i++) begin
         m[i*GW +: GW] = {GW{sel[i]}};
      end
      return m;
   endfunction

   state_e               state_q,      state_d;
   logic [CNT_W-1:0]     cnt_q,        cnt_d;
   logic [DW-1:0]        control_q,    control_d;
   logic [IRQ_WIDTH-1:0] irq_mask_q,   irq_mask_d;
   logic [IRQ_WIDTH-1:0] irq_status_q, irq_status_d;
   logic                 err_to_q,     err_to_d;
   logic [15:0]          err_addr_q,   err_addr_d;
   logic                 irq_q,        irq_d;
   logic                 ack_q,        ack_d;
   logic                 err_q,        err_d;
   logic [DW-1:0]        dat_q,        dat_d;
   logic [RW-1:0]        ip_addr_q,    ip_addr_d;
   logic [DW-1:0]        ip_wdata_q,   ip_wdata_d;
   logic [SEL_W-1:0]     ip_sel_q,     ip_sel_d;
   logic                 ip_rd_q,      ip_rd_d;
   logic                 ip_wr_q,      ip_wr_d;

   logic                 match_c;
   logic                 accept_c;
   logic                 is_reg_c;
   logic [RW-1:0]        offset_c;
   logic [2:0]           reg_idx_c;
   logic [DW-1:0]        wr_mask_c;
   logic [DW-1:0]        wr_bits_c;
   logic [DW-1:0]        rd_raw_c;
   logic [DW-1:0]        err_rd_c;
   logic [IRQ_WIDTH-1:0] irq_w1c_c;
   logic [IRQ_WIDTH-1:0] irq_w1s_c;

   // Address decode and acceptance.
   assign offset_c        = wb.i_wb_addr[RW-1:0];
   assign match_c         = (wb.i_wb_addr[AW-1:RW] == WB_BASE_ADDRESS[AW-1:RW]);
   assign wb.o_wb_stall   = wb.i_wb_cyc & (state_q != ST_IDLE);
   assign accept_c        = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_stall & match_c;
   assign is_reg_c        = (offset_c < IP_WINDOW);
   assign reg_idx_c       = offset_c[4:2];
   assign wr_mask_c       = lane_mask(wb.i_wb_sel);
   assign wr_bits_c       = wb.i_wb_dat & wr_mask_c;
   assign err_rd_c        = DW'({err_addr_q, 15'd0, err_to_q});

   // Register read mux, sampled at accept.
   always_comb begin
      rd_raw_c = '0;
      case (reg_idx_c)
         REG_VERSION:   rd_raw_c = IP_VERSION;
         REG_DEVICE_ID: rd_raw_c = IP_DEVICE_ID;
         REG_CONTROL:   rd_raw_c = control_q;
         REG_IRQ_MASK:  rd_raw_c = DW'(irq_mask_q);
         REG_IRQ_STAT:  rd_raw_c = DW'(irq_status_q);
         REG_STATUS:    rd_raw_c = i_ip_status;
         REG_IRQ_SET:   rd_raw_c = '0;
         default:       rd_raw_c = err_rd_c;
      endcase
   end

   // Next-state: register block, IP handshake, timeout and abort.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      control_d    = control_q;
      irq_mask_d   = irq_mask_q;
      err_to_d     = err_to_q;
      err_addr_d   = err_addr_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      dat_d        = '0;
      ip_addr_d    = ip_addr_q;
      ip_wdata_d   = ip_wdata_q;
      ip_sel_d     = ip_sel_q;
      ip_rd_d      = ip_rd_q;
      ip_wr_d      = ip_wr_q;
      irq_w1c_c    = '0;
      irq_w1s_c    = '0;

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (is_reg_c) begin
                  ack_d = 1'b1;
                  if (wb.i_wb_we) begin
                     case (reg_idx_c)
                        REG_CONTROL:  control_d  = (control_q & ~wr_mask_c) | wr_bits_c;
                        REG_IRQ_MASK: irq_mask_d = (irq_mask_q & ~IRQ_WIDTH'(wr_mask_c))
                                                 | IRQ_WIDTH'(wr_bits_c);
                        REG_IRQ_STAT: irq_w1c_c  = IRQ_WIDTH'(wr_bits_c);
                        REG_IRQ_SET:  irq_w1s_c  = IRQ_WIDTH'(wr_bits_c);
                        REG_ERROR:    if (wr_bits_c[0]) err_to_d = 1'b0;
                        default:      ;
                     endcase
                  end else begin
                     dat_d = rd_raw_c & wr_mask_c;
                  end
               end else begin
                  ip_addr_d  = offset_c;
                  ip_wdata_d = wb.i_wb_dat;
                  ip_sel_d   = wb.i_wb_sel;
                  ip_rd_d    = ~wb.i_wb_we;
                  ip_wr_d    = wb.i_wb_we;
                  cnt_d      = '0;
                  state_d    = ST_BUSY;
               end
            end
         end

         default: begin
            // Abort beats completion: a master that dropped CYC wants nothing back.
            if (!wb.i_wb_cyc) begin
               ip_rd_d = 1'b0;
               ip_wr_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (i_ip_ack) begin
               ack_d   = 1'b1;
               dat_d   = ip_wr_q ? '0 : (i_ip_rdata & lane_mask(ip_sel_q));
               ip_rd_d = 1'b0;
               ip_wr_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d      = 1'b1;
               err_to_d   = 1'b1;
               err_addr_d = 16'(ip_addr_q);
               ip_rd_d    = 1'b0;
               ip_wr_d    = 1'b0;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      // Hardware and software set take precedence over a same-cycle clear.
      irq_status_d = (irq_status_q & ~irq_w1c_c) | (irq_mask_q & i_ip_irq) | irq_w1s_c;
      irq_d        = |irq_status_q;
   end

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         control_q    <= '0;
         irq_mask_q   <= '0;
         irq_status_q <= '0;
         err_to_q     <= 1'b0;
         err_addr_q   <= '0;
         irq_q        <= 1'b0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         dat_q        <= '0;
         ip_addr_q    <= '0;
         ip_wdata_q   <= '0;
         ip_sel_q     <= '0;
         ip_rd_q      <= 1'b0;
         ip_wr_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         control_q    <= control_d;
         irq_mask_q   <= irq_mask_d;
         irq_status_q <= irq_status_d;
         err_to_q     <= err_to_d;
         err_addr_q   <= err_addr_d;
         irq_q        <= irq_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         dat_q        <= dat_d;
         ip_addr_q    <= ip_addr_d;
         ip_wdata_q   <= ip_wdata_d;
         ip_sel_q     <= ip_sel_d;
         ip_rd_q      <= ip_rd_d;
         ip_wr_q      <= ip_wr_d;
      end
   end

   // Terminations are withheld once the master has released the cycle.
   assign wb.o_wb_ack   = ack_q & wb.i_wb_cyc;
   assign wb.o_wb_err   = err_q & wb.i_wb_cyc;
   assign wb.o_wb_dat   = dat_q;

   assign o_ip_address  = ip_addr_q;
   assign o_ip_wdata    = ip_wdata_q;
   assign o_ip_sel      = ip_sel_q;
   assign o_ip_read_en  = ip_rd_q;
   assign o_ip_write_en = ip_wr_q;
   assign o_ip_control  = control_q;
   assign o_irq         = irq_q;

endmodule

// File: tb/tb_wb_pipelined_subordinate_if.sv
// Scoreboard bench for wb_pipelined_subordinate_if: stimulus pushes expected
// terminations, a negedge monitor pops and compares them.
module tb_wb_pipelined_subordinate_if;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] VER  = 32'hA5A5_0102;
   localparam logic [31:0] DID  = 32'h0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ip_address;
   logic [31:0] ip_wdata;
   logic [3:0]  ip_sel;
   logic        ip_read_en;
   logic        ip_write_en;
   logic [31:0] ip_rdata;
   logic        ip_ack;
   logic [31:0] ip_control;
   logic [31:0] ip_status;
   logic [7:0]  ip_irq;
   logic        irq;

   typedef struct packed {
      logic        is_err;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   wb_pipelined_subordinate_if_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) bus ();

   wb_pipelined_subordinate_if #(
      .WB_ADDRESS_WIDTH          (32),
      .WB_BASE_ADDRESS           (BASE),
      .WB_REGISTER_ADDRESS_WIDTH (16),
      .WB_DATA_WIDTH             (32),
      .WB_DATA_GRANULARITY       (8),
      .IRQ_WIDTH                 (8),
      .IP_TIMEOUT_CYCLES         (4),
      .IP_VERSION                (VER),
      .IP_DEVICE_ID              (DID)
   ) dut (
      .i_wb_clk      (clk),
      .i_wb_rst      (rst),
      .wb            (bus),
      .o_ip_address  (ip_address),
      .o_ip_wdata    (ip_wdata),
      .o_ip_sel      (ip_sel),
      .o_ip_read_en  (ip_read_en),
      .o_ip_write_en (ip_write_en),
      .i_ip_rdata    (ip_rdata),
      .i_ip_ack      (ip_ack),
      .o_ip_control  (ip_control),
      .i_ip_status   (ip_status),
      .i_ip_irq      (ip_irq),
      .o_irq         (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every termination must match the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst && (bus.o_wb_ack || bus.o_wb_err)) begin
         exp_t e;
         check("term_cyc_high", 32'(bus.i_wb_cyc), 32'd1);
         check("ack_err_exclusive", 32'(bus.o_wb_ack & bus.o_wb_err), 32'd0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_term actual ack=%0b err=%0b required none at %0t",
                     bus.o_wb_ack, bus.o_wb_err, $time);
         end else begin
            e = exp_q.pop_front();
            check("term_kind", {30'd0, bus.o_wb_ack, bus.o_wb_err},
                  e.is_err ? 32'd1 : 32'd2);
            check("term_data", bus.o_wb_dat, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d,
                        input logic [3:0] s);
      bus.i_wb_cyc  = 1'b1;
      bus.i_wb_stb  = 1'b1;
      bus.i_wb_addr = a;
      bus.i_wb_we   = we;
      bus.i_wb_dat  = d;
      bus.i_wb_sel  = s;
      @(posedge clk);
      #1;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
   endtask

   task automatic rd(input logic [15:0] off, input logic [3:0] s, input logic [31:0] expd);
      exp_q.push_back({1'b0, expd});
      issue(BASE | 32'(off), 1'b0, 32'd0, s);
   endtask

   task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s);
      exp_q.push_back({1'b0, 32'd0});
      issue(BASE | 32'(off), 1'b1, d, s);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.i_wb_cyc  = 1'b0;
      bus.i_wb_stb  = 1'b0;
      bus.i_wb_we   = 1'b0;
      bus.i_wb_addr = '0;
      bus.i_wb_dat  = '0;
      bus.i_wb_sel  = '0;
      ip_rdata      = '0;
      ip_ack        = 1'b0;
      ip_status     = '0;
      ip_irq        = '0;

      // Reset state
      #3;
      check("rst_ack", 32'(bus.o_wb_ack), 32'd0);
      check("rst_stall", 32'(bus.o_wb_stall), 32'd0);
      check("rst_dat", bus.o_wb_dat, 32'd0);
      check("rst_ip_en", {30'd0, ip_read_en, ip_write_en}, 32'd0);
      check("rst_control", ip_control, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back ID reads
      rd(16'h0000, 4'hF, VER);
      rd(16'h0004, 4'hF, DID);
      check("b2b_stall", 32'(bus.o_wb_stall), 32'd0);
      check("b2b_second_ack", 32'(bus.o_wb_ack), 32'd1);
      idle(2);

      // CONTROL lane merge and read lane masking
      wr(16'h0008, 32'hAABB_CCDD, 4'b0101);
      check("control_out", ip_control, 32'h00BB_00DD);
      rd(16'h0008, 4'hF, 32'h00BB_00DD);
      rd(16'h0008, 4'b0011, 32'h0000_00DD);

      // IRQ_MASK implemented width, then mask bit 0 only
      wr(16'h000C, 32'hFFFF_FFFF, 4'hF);
      rd(16'h000C, 4'hF, 32'h0000_00FF);
      wr(16'h000C, 32'h0000_0001, 4'hF);
      idle(1);

      // IRQ pulse: only the unmasked line latches
      ip_irq = 8'h03;
      @(posedge clk);
      #1;
      ip_irq = 8'h00;
      idle(1);
      check("irq_set", 32'(irq), 32'd1);
      rd(16'h0010, 4'hF, 32'h0000_0001);

      // W1C while source still high keeps the bit
      ip_irq = 8'h01;
      wr(16'h0010, 32'h0000_0001, 4'hF);
      rd(16'h0010, 4'hF, 32'h0000_0001);
      ip_irq = 8'h00;
      wr(16'h0010, 32'h0000_0001, 4'hF);
      rd(16'h0010, 4'hF, 32'h0000_0000);
      check("irq_cleared", 32'(irq), 32'd0);

      // Software set
      wr(16'h0018, 32'h0000_0080, 4'hF);
      rd(16'h0018, 4'hF, 32'h0000_0000);
      rd(16'h0010, 4'hF, 32'h0000_0080);
      idle(1);
      check("irq_sw_set", 32'(irq), 32'd1);

      // STATUS with partial lanes; RO write ignored
      ip_status = 32'h5A5A_1234;
      rd(16'h0014, 4'b1100, 32'h5A5A_0000);
      wr(16'h0000, 32'h0000_0000, 4'hF);
      rd(16'h0000, 4'hF, VER);
      idle(1);

      // IP read acked in the third busy cycle
      rd(16'h0040, 4'hF, 32'h1234_5678);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("ipr_stall", 32'(bus.o_wb_stall), 32'd1);
         check("ipr_en", {30'd0, ip_read_en, ip_write_en}, 32'd2);
         if (k == 3) begin
            ip_ack   = 1'b1;
            ip_rdata = 32'h1234_5678;
         end
      end
      check("ipr_addr", 32'(ip_address), 32'h0000_0040);
      @(posedge clk);
      #1;
      ip_ack   = 1'b0;
      ip_rdata = '0;
      @(negedge clk);
      check("ipr_done_stall", 32'(bus.o_wb_stall), 32'd0);
      check("ipr_done_en", 32'(ip_read_en), 32'd0);

      // IP write acked in the first busy cycle
      @(posedge clk);
      #1;
      wr(16'h0048, 32'hDEAD_BEEF, 4'b1010);
      @(negedge clk);
      check("ipw_en", {30'd0, ip_read_en, ip_write_en}, 32'd1);
      check("ipw_wdata", ip_wdata, 32'hDEAD_BEEF);
      check("ipw_sel", 32'(ip_sel), 32'h0000_000A);
      ip_ack = 1'b1;
      @(posedge clk);
      #1;
      ip_ack = 1'b0;
      @(negedge clk);
      check("ipw_done_en", 32'(ip_write_en), 32'd0);

      // IP write times out after four busy cycles
      @(posedge clk);
      #1;
      exp_q.push_back({1'b1, 32'd0});
      issue(BASE | 32'h0000_0044, 1'b1, 32'h0000_0011, 4'hF);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("to_en", 32'(ip_write_en), 32'd1);
      end
      @(negedge clk);
      check("to_en_drop", 32'(ip_write_en), 32'd0);
      check("to_stall_drop", 32'(bus.o_wb_stall), 32'd0);
      @(posedge clk);
      #1;
      rd(16'h001C, 4'hF, 32'h0044_0001);
      wr(16'h001C, 32'h0000_0001, 4'hF);
      rd(16'h001C, 4'hF, 32'h0044_0000);
      idle(1);

      // Register ack whose cycle was released is withheld
      issue(BASE, 1'b0, 32'd0, 4'hF);
      bus.i_wb_cyc = 1'b0;
      @(negedge clk);
      check("suppressed_ack", 32'(bus.o_wb_ack), 32'd0);
      idle(1);

      // Address outside the core window: no stall, no termination
      issue(32'h5000_0000, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      check("nomatch_stall", 32'(bus.o_wb_stall), 32'd0);
      check("nomatch_en", 32'(ip_read_en), 32'd0);
      idle(2);

      // CYC dropped during an IP read aborts silently
      issue(BASE | 32'h0000_004C, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      check("abort_en1", 32'(ip_read_en), 32'd1);
      @(negedge clk);
      check("abort_en2", 32'(ip_read_en), 32'd1);
      @(posedge clk);
      #1;
      bus.i_wb_cyc = 1'b0;
      @(negedge clk);
      check("abort_en_hold", 32'(ip_read_en), 32'd1);
      @(negedge clk);
      check("abort_en_drop", 32'(ip_read_en), 32'd0);
      @(posedge clk);
      #1;
      rd(16'h0000, 4'hF, VER);
      idle(1);

      // Asynchronous reset in the middle of an IP access
      issue(BASE | 32'h0000_0050, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      check("mid_en", 32'(ip_read_en), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_en", {30'd0, ip_read_en, ip_write_en}, 32'd0);
      check("arst_stall", 32'(bus.o_wb_stall), 32'd0);
      check("arst_term", {30'd0, bus.o_wb_ack, bus.o_wb_err}, 32'd0);
      check("arst_control", ip_control, 32'd0);
      check("arst_irq", 32'(irq), 32'd0);
      check("arst_addr", 32'(ip_address), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
